rx_frame_buffer_ctl: RTL and testbench

- Receive-side controller between the HDLC deframer and the host/bridge logic.
- Edge-detects the deframer's byte/frame status levels and writes frame bytes into an internal byte ring buffer.
- Strips the 2 FCS bytes, then commits good frames as {start, length} descriptors in a descriptor queue, or rolls back bad, aborted or overflowed frames.
- Host side pops committed frames through a simple read port and keeps saturating error statistics.

---
 rtl/rx_frame_buffer_ctl.sv | 191 +++++++++++++++++++
 tb/tb_rx_frame_buffer_ctl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_buffer_ctl.sv
// Receive frame buffer: edge-detects deframer status, stores frame bytes in a byte ring,
// strips FCS and queues {start, length} descriptors for the host read port.
module rx_frame_buffer_ctl #(
    parameter int ADDR_W  = 11,
    parameter int DQ_W    = 3,
    parameter int MIN_LEN = 4,
    parameter int MAX_LEN = 1282
) (
    input  logic              netclk,
    input  logic              reset,
    input  logic              rx_enable,
    input  logic              byte_ready,
    input  logic [7:0]        dout,
    input  logic              frame_complete,
    input  logic              frame_valid,
    input  logic              frame_abort,
    output logic              frame_avail,
    output logic [ADDR_W:0]   frame_len,
    input  logic              rd_en,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    input  logic              frame_pop,
    output logic [7:0]        crc_err_cnt,
    output logic [7:0]        abort_cnt,
    output logic [7:0]        drop_cnt
);

    localparam int CNT_W = 16;
    localparam int DQ_N  = 1 << DQ_W;
    localparam int RAM_N = 1 << ADDR_W;

    typedef enum logic {IDLE, RECV} state_t;

    state_t              r_state;
    logic                r_byte_d, r_done_d, r_abort_d;
    logic [ADDR_W-1:0]   r_wr_ptr, r_commit_ptr;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_ovf;
    logic [DQ_W-1:0]     r_dq_wp, r_dq_rp;
    logic [DQ_W:0]       r_dq_cnt;
    logic [ADDR_W:0]     r_rd_off;
    logic [7:0]          r_rd_data;
    logic                r_rd_valid;
    logic [7:0]          r_crc_cnt, r_abort_cnt, r_drop_cnt;

    logic [7:0]          r_ram      [RAM_N];
    logic [ADDR_W-1:0]   r_dq_start [DQ_N];
    logic [ADDR_W:0]     r_dq_len   [DQ_N];

    logic                w_byte_ev, w_done_ev, w_abort_ev;
    logic                w_avail, w_dq_full, w_ring_full, w_cnt_max, w_runt;
    logic                w_recv, w_recv_ok, w_ram_we, w_push, w_pop, w_rd_ok;
    logic [ADDR_W-1:0]   w_rd_base, w_limit, w_wr_next, w_rd_addr, w_commit_new;
    logic [ADDR_W:0]     w_push_len;

    assign w_byte_ev  = byte_ready & ~r_byte_d;
    assign w_done_ev  = frame_complete & ~r_done_d;
    assign w_abort_ev = frame_abort & ~r_abort_d;

    assign w_avail     = (r_dq_cnt != '0);
    assign w_dq_full   = (r_dq_cnt == (DQ_W+1)'(DQ_N));
    assign w_rd_base   = r_dq_start[r_dq_rp];
    // With no frame queued, the oldest live byte is the commit point itself.
    assign w_limit     = w_avail ? w_rd_base : r_commit_ptr;
    assign w_wr_next   = r_wr_ptr + ADDR_W'(1);
    assign w_ring_full = (w_wr_next == w_limit);
    assign w_cnt_max   = (r_cnt == CNT_W'(MAX_LEN));
    assign w_runt      = (r_cnt < CNT_W'(MIN_LEN));
    assign w_commit_new = r_wr_ptr - ADDR_W'(2);
    assign w_push_len  = (ADDR_W+1)'(r_cnt - CNT_W'(2));

    // RECV with no abort and no disable: done or byte may act this cycle.
    assign w_recv    = (r_state == RECV);
    assign w_recv_ok = w_recv & ~w_abort_ev & rx_enable;
    assign w_ram_we  = ((r_state == IDLE) & w_byte_ev & rx_enable) |
                       (w_recv_ok & ~w_done_ev & w_byte_ev & ~r_ovf & ~w_ring_full & ~w_cnt_max);
    assign w_push    = w_recv_ok & w_done_ev & ~r_ovf & ~w_runt & ~w_dq_full & frame_valid;
    assign w_pop     = frame_pop & w_avail;
    assign w_rd_ok   = rd_en & w_avail & (r_rd_off < frame_len);
    assign w_rd_addr = w_rd_base + r_rd_off[ADDR_W-1:0];

    assign frame_avail = w_avail;
    assign frame_len   = w_avail ? r_dq_len[r_dq_rp] : '0;
    assign rd_data     = r_rd_data;
    assign rd_valid    = r_rd_valid;
    assign crc_err_cnt = r_crc_cnt;
    assign abort_cnt   = r_abort_cnt;
    assign drop_cnt    = r_drop_cnt;

    always_ff @(posedge netclk) begin
        if (w_ram_we)
            r_ram[r_wr_ptr] <= dout;
        if (w_push) begin
            r_dq_start[r_dq_wp] <= r_commit_ptr;
            r_dq_len[r_dq_wp]   <= w_push_len;
        end
    end

    always_ff @(posedge netclk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_byte_d     <= 1'b0;
            r_done_d     <= 1'b0;
            r_abort_d    <= 1'b0;
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_cnt        <= '0;
            r_ovf        <= 1'b0;
            r_dq_wp      <= '0;
            r_dq_rp      <= '0;
            r_dq_cnt     <= '0;
            r_rd_off     <= '0;
            r_rd_data    <= '0;
            r_rd_valid   <= 1'b0;
            r_crc_cnt    <= '0;
            r_abort_cnt  <= '0;
            r_drop_cnt   <= '0;
        end else begin
            r_byte_d  <= byte_ready;
            r_done_d  <= frame_complete;
            r_abort_d <= frame_abort;

            case (r_state)
                IDLE: begin
                    if (w_byte_ev && rx_enable) begin
                        r_wr_ptr <= w_wr_next;
                        r_cnt    <= CNT_W'(1);
                        r_ovf    <= 1'b0;
                        r_state  <= RECV;
                    end
                end
                RECV: begin
                    if (w_abort_ev) begin
                        r_wr_ptr <= r_commit_ptr;
                        r_ovf    <= 1'b0;
                        if (r_abort_cnt != 8'hFF)
                            r_abort_cnt <= r_abort_cnt + 8'd1;
                        r_state  <= IDLE;
                    end else if (!rx_enable) begin
                        r_wr_ptr <= r_commit_ptr;
                        r_ovf    <= 1'b0;
                        r_state  <= IDLE;
                    end else if (w_done_ev) begin
                        r_ovf   <= 1'b0;
                        r_state <= IDLE;
                        if (r_ovf || w_runt || w_dq_full) begin
                            r_wr_ptr <= r_commit_ptr;
                            if (r_drop_cnt != 8'hFF)
                                r_drop_cnt <= r_drop_cnt + 8'd1;
                        end else if (!frame_valid) begin
                            r_wr_ptr <= r_commit_ptr;
                            if (r_crc_cnt != 8'hFF)
                                r_crc_cnt <= r_crc_cnt + 8'd1;
                        end else begin
                            // Drop the two FCS bytes by backing both pointers over them.
                            r_wr_ptr     <= w_commit_new;
                            r_commit_ptr <= w_commit_new;
                        end
                    end else if (w_byte_ev) begin
                        if (r_ovf || w_ring_full || w_cnt_max) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_wr_ptr <= w_wr_next;
                            r_cnt    <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_push)
                r_dq_wp <= r_dq_wp + DQ_W'(1);
            if (w_pop)
                r_dq_rp <= r_dq_rp + DQ_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_dq_cnt <= r_dq_cnt + (DQ_W+1)'(1);
                2'b01:   r_dq_cnt <= r_dq_cnt - (DQ_W+1)'(1);
                default: r_dq_cnt <= r_dq_cnt;
            endcase

            r_rd_valid <= w_rd_ok;
            if (w_rd_ok)
                r_rd_data <= r_ram[w_rd_addr];
            if (w_pop)
                r_rd_off <= '0;
            else if (w_rd_ok)
                r_rd_off <= r_rd_off + (ADDR_W+1)'(1);
        end
    end

endmodule

// File: tb/tb_rx_frame_buffer_ctl.sv
// Directed bench for rx_frame_buffer_ctl on a 32-byte ring with MAX_LEN=20 so that
// wrap, ring-full, max-length and queue-full cases are reachable in few cycles.
module tb_rx_frame_buffer_ctl;

    localparam int AW = 5;

    logic          netclk = 1'b0;
    logic          reset = 1'b1;
    logic          rx_enable = 1'b0;
    logic          byte_ready = 1'b0;
    logic [7:0]    dout = 8'h00;
    logic          frame_complete = 1'b0;
    logic          frame_valid = 1'b0;
    logic          frame_abort = 1'b0;
    logic          frame_avail;
    logic [AW:0]   frame_len;
    logic          rd_en = 1'b0;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic          frame_pop = 1'b0;
    logic [7:0]    crc_err_cnt, abort_cnt, drop_cnt;

    int checks = 0;
    int errors = 0;

    rx_frame_buffer_ctl #(.ADDR_W(AW), .DQ_W(3), .MIN_LEN(4), .MAX_LEN(20)) dut (
        .netclk(netclk), .reset(reset), .rx_enable(rx_enable),
        .byte_ready(byte_ready), .dout(dout), .frame_complete(frame_complete),
        .frame_valid(frame_valid), .frame_abort(frame_abort),
        .frame_avail(frame_avail), .frame_len(frame_len), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .frame_pop(frame_pop),
        .crc_err_cnt(crc_err_cnt), .abort_cnt(abort_cnt), .drop_cnt(drop_cnt)
    );

    always #5 netclk = ~netclk;

    task automatic send_byte(input logic [7:0] b);
        @(negedge netclk); dout = b; byte_ready = 1'b1;
        @(negedge netclk); byte_ready = 1'b0;
    endtask

    task automatic send_bytes(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) send_byte(base + 8'(i));
    endtask

    task automatic close_frame(input logic v);
        @(negedge netclk); frame_valid = v; frame_complete = 1'b1;
        @(negedge netclk); frame_complete = 1'b0;
        @(negedge netclk);
    endtask

    task automatic send_frame(input int pl, input logic [7:0] base, input logic v);
        send_bytes(pl, base);
        send_byte(8'hF0);
        send_byte(8'hF1);
        close_frame(v);
    endtask

    task automatic do_read(output logic v, output logic [7:0] d);
        @(negedge netclk); rd_en = 1'b1;
        @(negedge netclk); rd_en = 1'b0;
        v = rd_valid; d = rd_data;
    endtask

    task automatic pop;
        @(negedge netclk); frame_pop = 1'b1;
        @(negedge netclk); frame_pop = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge netclk);
        checks++;
        if ({frame_avail, frame_len, rd_data, rd_valid} !== '0) begin
            errors++;
            $display("FAIL reset_host: got avail=%0b len=%0d data=%0h vld=%0b expected all 0",
                     frame_avail, frame_len, rd_data, rd_valid);
        end
        checks++;
        if ({crc_err_cnt, abort_cnt, drop_cnt} !== 24'h0) begin
            errors++;
            $display("FAIL reset_cnt: got %0h/%0h/%0h expected 0/0/0", crc_err_cnt, abort_cnt, drop_cnt);
        end
        reset = 1'b0;
        rx_enable = 1'b1;
        @(negedge netclk);
    endtask

    task automatic test_good_frame;
        logic v; logic [7:0] d;
        send_frame(3, 8'h01, 1'b1);
        checks++;
        if (frame_avail !== 1'b1 || frame_len !== 6'd3) begin
            errors++;
            $display("FAIL good_desc: got avail=%0b len=%0d expected 1/3", frame_avail, frame_len);
        end
        for (int i = 0; i < 3; i++) begin
            do_read(v, d);
            checks++;
            if (v !== 1'b1 || d !== 8'h01 + 8'(i)) begin
                errors++;
                $display("FAIL good_read%0d: got vld=%0b data=%0h expected 1/%0h", i, v, d, 8'h01 + 8'(i));
            end
        end
        do_read(v, d);
        checks++;
        if (v !== 1'b0) begin
            errors++;
            $display("FAIL read_past_end: got vld=%0b expected 0", v);
        end
        pop;
        checks++;
        if (frame_avail !== 1'b0) begin
            errors++;
            $display("FAIL good_pop: got avail=%0b expected 0", frame_avail);
        end
    endtask

    task automatic test_bad_fcs;
        logic v; logic [7:0] d;
        send_frame(4, 8'h40, 1'b0);
        checks++;
        if (crc_err_cnt !== 8'd1 || frame_avail !== 1'b0) begin
            errors++;
            $display("FAIL bad_fcs: got crc=%0d avail=%0b expected 1/0", crc_err_cnt, frame_avail);
        end
        send_frame(2, 8'h10, 1'b1);
        checks++;
        if (frame_len !== 6'd2) begin
            errors++;
            $display("FAIL after_crc_len: got %0d expected 2", frame_len);
        end
        for (int i = 0; i < 2; i++) begin
            do_read(v, d);
            checks++;
            if (v !== 1'b1 || d !== 8'h10 + 8'(i)) begin
                errors++;
                $display("FAIL after_crc_read%0d: got %0b/%0h expected 1/%0h", i, v, d, 8'h10 + 8'(i));
            end
        end
        pop;
    endtask

    task automatic test_abort;
        logic v; logic [7:0] d;
        send_bytes(4, 8'h50);
        @(negedge netclk); frame_abort = 1'b1;
        @(negedge netclk); frame_abort = 1'b0;
        @(negedge netclk);
        checks++;
        if (abort_cnt !== 8'd1 || frame_avail !== 1'b0) begin
            errors++;
            $display("FAIL abort: got cnt=%0d avail=%0b expected 1/0", abort_cnt, frame_avail);
        end
        send_frame(2, 8'h20, 1'b1);
        for (int i = 0; i < 2; i++) begin
            do_read(v, d);
            checks++;
            if (v !== 1'b1 || d !== 8'h20 + 8'(i)) begin
                errors++;
                $display("FAIL after_abort_read%0d: got %0b/%0h expected 1/%0h", i, v, d, 8'h20 + 8'(i));
            end
        end
        pop;
    endtask

    task automatic test_runt_overflow;
        logic v; logic [7:0] d;
        send_frame(1, 8'h60, 1'b1);
        checks++;
        if (drop_cnt !== 8'd1 || frame_avail !== 1'b0) begin
            errors++;
            $display("FAIL runt: got drop=%0d avail=%0b expected 1/0", drop_cnt, frame_avail);
        end
        send_frame(19, 8'h80, 1'b1);
        checks++;
        if (drop_cnt !== 8'd2 || frame_avail !== 1'b0) begin
            errors++;
            $display("FAIL max_len_plus1: got drop=%0d avail=%0b expected 2/0", drop_cnt, frame_avail);
        end
        send_frame(18, 8'h90, 1'b1);
        checks++;
        if (frame_len !== 6'd18) begin
            errors++;
            $display("FAIL max_len_len: got %0d expected 18", frame_len);
        end
        for (int i = 0; i < 18; i++) begin
            do_read(v, d);
            checks++;
            if (v !== 1'b1 || d !== 8'h90 + 8'(i)) begin
                errors++;
                $display("FAIL max_len_read%0d: got %0b/%0h expected 1/%0h", i, v, d, 8'h90 + 8'(i));
            end
        end
        pop;
        // Two held frames leave 11 free bytes; the 100-byte frame must overflow.
        send_frame(10, 8'hA0, 1'b1);
        send_frame(10, 8'hB0, 1'b1);
        send_frame(98, 8'h00, 1'b1);
        checks++;
        if (drop_cnt !== 8'd3 || frame_len !== 6'd10) begin
            errors++;
            $display("FAIL ring_full: got drop=%0d len=%0d expected 3/10", drop_cnt, frame_len);
        end
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 10; i++) begin
                do_read(v, d);
                checks++;
                if (v !== 1'b1 || d !== 8'hA0 + 8'(16 * f) + 8'(i)) begin
                    errors++;
                    $display("FAIL held_read%0d_%0d: got %0b/%0h expected 1/%0h",
                             f, i, v, d, 8'hA0 + 8'(16 * f) + 8'(i));
                end
            end
            pop;
        end
    endtask

    task automatic test_wrap;
        logic v; logic [7:0] d;
        send_frame(15, 8'hC0, 1'b1);
        pop;
        send_frame(5, 8'hD0, 1'b1);
        checks++;
        if (frame_len !== 6'd5) begin
            errors++;
            $display("FAIL wrap_len: got %0d expected 5", frame_len);
        end
        for (int i = 0; i < 5; i++) begin
            do_read(v, d);
            checks++;
            if (v !== 1'b1 || d !== 8'hD0 + 8'(i)) begin
                errors++;
                $display("FAIL wrap_read%0d: got %0b/%0h expected 1/%0h", i, v, d, 8'hD0 + 8'(i));
            end
        end
        pop;
    endtask

    task automatic test_queue_full;
        int ql[8] = '{2, 3, 4, 2, 3, 4, 2, 3};
        for (int i = 0; i < 8; i++) send_frame(ql[i], 8'(i * 16), 1'b1);
        checks++;
        if (frame_avail !== 1'b1 || frame_len !== 6'd2) begin
            errors++;
            $display("FAIL queue_head: got avail=%0b len=%0d expected 1/2", frame_avail, frame_len);
        end
        send_frame(2, 8'hEE, 1'b1);
        checks++;
        if (drop_cnt !== 8'd4) begin
            errors++;
            $display("FAIL queue_full_drop: got %0d expected 4", drop_cnt);
        end
        pop;
        checks++;
        if (frame_len !== 6'd3) begin
            errors++;
            $display("FAIL queue_pop_len: got %0d expected 3", frame_len);
        end
    endtask

    task automatic test_back_to_back;
        logic v; logic [7:0] d;
        send_bytes(2, 8'hE0);
        send_byte(8'hF0);
        send_byte(8'hF1);
        @(negedge netclk); frame_valid = 1'b1; frame_complete = 1'b1; frame_pop = 1'b1;
        @(negedge netclk); frame_complete = 1'b0; frame_pop = 1'b0;
        checks++;
        if (frame_avail !== 1'b1 || frame_len !== 6'd4) begin
            errors++;
            $display("FAIL push_pop: got avail=%0b len=%0d expected 1/4", frame_avail, frame_len);
        end
        repeat (6) pop;
        checks++;
        if (frame_avail !== 1'b1 || frame_len !== 6'd2) begin
            errors++;
            $display("FAIL pushed_frame_len: got avail=%0b len=%0d expected 1/2", frame_avail, frame_len);
        end
        for (int i = 0; i < 2; i++) begin
            do_read(v, d);
            checks++;
            if (v !== 1'b1 || d !== 8'hE0 + 8'(i)) begin
                errors++;
                $display("FAIL pushed_read%0d: got %0b/%0h expected 1/%0h", i, v, d, 8'hE0 + 8'(i));
            end
        end
        pop;
        checks++;
        if (frame_avail !== 1'b0) begin
            errors++;
            $display("FAIL queue_drained: got avail=%0b expected 0", frame_avail);
        end
    endtask

    task automatic test_reset_mid;
        logic v; logic [7:0] d;
        send_frame(2, 8'h44, 1'b1);
        send_bytes(3, 8'h33);
        @(negedge netclk); reset = 1'b1;
        @(negedge netclk);
        checks++;
        if ({frame_avail, frame_len, rd_valid, crc_err_cnt, abort_cnt, drop_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_mid: got avail=%0b len=%0d vld=%0b cnt=%0h/%0h/%0h expected all 0",
                     frame_avail, frame_len, rd_valid, crc_err_cnt, abort_cnt, drop_cnt);
        end
        reset = 1'b0;
        send_frame(3, 8'h70, 1'b1);
        checks++;
        if (frame_avail !== 1'b1 || frame_len !== 6'd3) begin
            errors++;
            $display("FAIL post_reset_desc: got avail=%0b len=%0d expected 1/3", frame_avail, frame_len);
        end
        for (int i = 0; i < 3; i++) begin
            do_read(v, d);
            checks++;
            if (v !== 1'b1 || d !== 8'h70 + 8'(i)) begin
                errors++;
                $display("FAIL post_reset_read%0d: got %0b/%0h expected 1/%0h", i, v, d, 8'h70 + 8'(i));
            end
        end
    endtask

    initial begin
        test_reset;
        test_good_frame;
        test_bad_fcs;
        test_abort;
        test_runt_overflow;
        test_wrap;
        test_queue_full;
        test_back_to_back;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "timeout");
    end

endmodule
